alu_mc: RTL and testbench

Multi-cycle, parametrised execution-stage ALU with valid/ready handshakes on both sides. Single-cycle ops (add, sub, logic, compare) complete in one clock; multiply runs as an iterative shift-add over WIDTH clocks, so the datapath holds no full-width array multiplier. Sits between the ID/EX pipeline register and EX/MEM. The decode stage issues through `in_*` and EX/MEM drains through `out_*`.

---
 rtl/alu_mc.sv | 151 +++++++++++++++
 tb/tb_alu_mc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: execution-stage ALU, single-cycle ADD/SUB/AND/OR/SLT plus iterative shift-add MUL, valid/ready both sides.
// ALU_MUL_HI_EN: when defined, MUL returns the high product half on o_result_hi; otherwise MUL exits early and o_result_hi is 0.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_data1,
  input  logic [WIDTH-1:0]  i_data2,
  input  logic [CTRL_W-1:0] i_alu_control,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_result,
  output logic [WIDTH-1:0]  o_result_hi,
  output logic              o_zero,
  output logic              o_illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_BUSY = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;

  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(5);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_illegal;
  logic             w_slt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_mul_last;

`ifdef ALU_MUL_HI_EN
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_result_hi;
  logic [WIDTH:0]   w_upper;
  logic [2*WIDTH:0] w_acc_next;

  // Add into the upper half, then shift the whole accumulator right one place.
  assign w_upper    = r_mplr[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand}) : r_acc[2*WIDTH:WIDTH];
  assign w_acc_next = {w_upper, r_acc[WIDTH-1:0]} >> 1;
  assign w_mul_last = (r_cnt == CW'(1));
  assign o_result_hi = r_result_hi;
`else
  logic [WIDTH:0]   r_acc;
  logic [WIDTH:0]   w_acc_next;

  // Low half only: shift the multiplicand left instead, so stopping early leaves result aligned.
  assign w_acc_next = r_mplr[0] ? (r_acc + {1'b0, r_mcand}) : r_acc;
  assign w_mul_last = (r_cnt == CW'(1)) || (r_mplr[WIDTH-1:1] == '0);
  assign o_result_hi = '0;
`endif

  assign o_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_illegal   = r_illegal;

  assign w_accept = i_in_valid && o_in_ready;
  assign w_is_mul = (i_alu_control == OP_MUL);
  assign w_slt    = $signed(i_data1) < $signed(i_data2);

  always_comb begin
    w_alu_res = '0;
    w_illegal = 1'b0;
    case (i_alu_control)
      OP_ADD:  w_alu_res = i_data1 + i_data2;
      OP_SUB:  w_alu_res = i_data1 - i_data2;
      OP_MUL:  w_alu_res = '0;
      OP_AND:  w_alu_res = i_data1 & i_data2;
      OP_OR:   w_alu_res = i_data1 | i_data2;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_MUL_HI_EN
      r_result_hi <= '0;
`endif
    end else begin
      case (r_state)
        S_MUL_BUSY: begin
          r_acc  <= w_acc_next;
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt - CW'(1);
`ifndef ALU_MUL_HI_EN
          r_mcand <= r_mcand << 1;
`endif
          if (w_mul_last) begin
            r_state  <= S_DONE;
            r_result <= w_acc_next[WIDTH-1:0];
`ifdef ALU_MUL_HI_EN
            r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
`endif
          end
        end
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_zero    <= (i_data1 == i_data2);
            r_illegal <= w_illegal;
            if (w_is_mul) begin
              r_state <= S_MUL_BUSY;
              r_mcand <= i_data1;
              r_mplr  <= i_data2;
              r_acc   <= '0;
              r_cnt   <= CW'(WIDTH);
            end else begin
              r_state  <= S_DONE;
              r_result <= w_alu_res;
`ifdef ALU_MUL_HI_EN
              r_result_hi <= '0;
`endif
            end
          end else if ((r_state == S_DONE) && i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32): expected results are queued at accept and checked while out_valid is high.
module tb_alu_mc;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [3:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        illegal;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   seen = 1'b0;
  bit   rnd_done = 1'b0;
  exp_t sb[$];

  alu_mc #(.WIDTH(32), .CTRL_W(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_data1       (data1),
    .i_data2       (data2),
    .i_alu_control (alu_control),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_result      (result),
    .o_result_hi   (result_hi),
    .o_zero        (zero),
    .o_illegal     (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.res = '0;
    e.hi  = '0;
    e.z   = (a == b);
    e.ill = 1'b0;
    e.lat = 0;
    e.acc = 0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0];
`ifdef ALU_MUL_HI_EN
        e.hi  = p[63:32];
        e.lat = 32;
`else
        e.lat = 1;
        for (int i = 0; i < 32; i++) if (b[i]) e.lat = i + 1;
`endif
      end
      4'd3: e.res = a & b;
      4'd4: e.res = a | b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one op and hold it until accepted; caller is always at posedge+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit   got;
    exp_t e;
    got = 1'b0;
    in_valid = 1'b1;
    alu_control = op;
    data1 = a;
    data2 = b;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (got) begin
      e = model(op, a, b);
      e.acc = cyc;
      sb.push_back(e);
    end else begin
      chk("accept_timeout", 64'(0), 64'(1));
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) tick(1);
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(out_valid), 64'(0));
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        chk("result", 64'(result), 64'(sb[0].res));
        chk("result_hi", 64'(result_hi), 64'(sb[0].hi));
        chk("zero", 64'(zero), 64'(sb[0].z));
        chk("illegal", 64'(illegal), 64'(sb[0].ill));
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [3:0] optab [7];
    optab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15};

    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_result_hi", 64'(result_hi), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    tick(1);

    issue(4'd0, 32'd5, 32'd7);
    issue(4'd1, 32'd3, 32'd3);
    wait_drain();

    // Full-length multiply: in_ready must stay low for the whole busy phase.
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) break;
      chk("mul_busy_in_ready", 64'(in_ready), 64'(0));
    end
    tick(1);
    wait_drain();
    issue(4'd2, 32'd6, 32'd3);
    wait_drain();

    issue(4'd0, 32'd100, 32'd23);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);
    issue(4'd4, 32'h0000_00F0, 32'h0000_000F);
    wait_drain();

    out_ready = 1'b0;
    issue(4'd3, 32'h0000_FF00, 32'h0000_0FF0);
    in_valid = 1'b1;
    alu_control = 4'd1;
    data1 = 32'd9;
    data2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      tick(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    issue(4'd15, 32'd9, 32'd9);
    issue(4'd0, 32'd1, 32'd1);
    wait_drain();

    issue(4'd2, 32'h1234_5678, 32'h09AB_CDEF);
    issue(4'd2, 32'hDEAD_BEEF, 32'd0);
    issue(4'd2, 32'h8000_0000, 32'd1);
    wait_drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [31:0] a;
          logic [31:0] b;
          a = $urandom;
          b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
          issue(optab[$urandom_range(0, 6)], a, b);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Abort a multiply mid-flight; nothing may come out for it afterwards.
    issue(4'd2, 32'hFFFF_FFFF, 32'h8000_0001);
    tick(9);
    reset = 1'b1;
    sb.delete();
    seen = 1'b0;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_illegal", 64'(illegal), 64'(0));
    tick(1);
    tick(40);
    issue(4'd0, 32'hFFFF_FFFF, 32'd2);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
